// File: rtl/mux_pkg.sv
// Shared constants and helpers for the registered N:1 stream multiplexer.
package mux_pkg;

    localparam int MODE_SEL = 0;
    localparam int MODE_RR  = 1;

    // Width of a channel select/pointer; a 1- or 2-channel mux still needs one bit.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester at or above ptr, wrapping.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N  = 4,
    parameter int SW = sel_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [N-1:0]  grant
);

    always_comb begin
        logic found;
        grant = '0;
        found = 1'b0;
        // First pass covers ptr..N-1; the second pass only matters when nothing there requested.
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (SW'(i) >= ptr)) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && req[i]) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_n_to_1_reg.sv
// N-input, W-bit stream multiplexer with a single registered output stage and valid/ready
// handshakes; channel picked by external select or by an internal round-robin arbiter.
module mux_n_to_1_reg
    import mux_pkg::*;
#(
    parameter int N    = 4,
    parameter int W    = 8,
    parameter int MODE = MODE_SEL,
    parameter int SW   = sel_width(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    input  logic [SW-1:0]  sel,
    output logic [W-1:0]   out_data,
    output logic           out_valid,
    input  logic           out_ready
);

    logic [N-1:0] grant;
    logic [N-1:0] take;
    logic         load_en;
    logic [W-1:0] mux_data;
    logic [W-1:0] out_data_q, out_data_d;
    logic         out_valid_q, out_valid_d;

    assign load_en  = !out_valid_q || out_ready;
    assign in_ready = (load_en && !rst) ? grant : '0;
    assign take     = in_valid & in_ready;

    if (MODE == MODE_RR) begin : g_rr
        logic [SW-1:0] ptr_q, ptr_d;
        logic          unused_sel;

        assign unused_sel = ^sel;

        rr_arbiter #(.N(N), .SW(SW)) u_arb (
            .req   (in_valid),
            .ptr   (ptr_q),
            .grant (grant)
        );

        // Wrap by explicit compare so non-power-of-two N never lands on an idle pointer value.
        always_comb begin
            ptr_d = ptr_q;
            for (int i = 0; i < N; i++) begin
                if (take[i]) ptr_d = (i == N - 1) ? '0 : SW'(i + 1);
            end
        end

        always_ff @(posedge clk) begin
            if (rst) ptr_q <= '0;
            else     ptr_q <= ptr_d;
        end
    end else begin : g_sel
        // An out-of-range select matches no channel, so grant stays all zero.
        always_comb begin
            grant = '0;
            for (int i = 0; i < N; i++) begin
                if (sel == SW'(i)) grant[i] = 1'b1;
            end
        end
    end

    always_comb begin
        mux_data = '0;
        for (int i = 0; i < N; i++) begin
            if (take[i]) mux_data = in_data[i*W +: W];
        end
    end

    // NOTE: every variable gets a default before any branch, so no path leaves it unassigned (no latch).
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (|take) begin
            out_valid_d = 1'b1;
            out_data_d  = mux_data;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule
